// File: rtl/float_expand_if.sv
// Bus between a sample producer and float_expand: input sample handshake,
// output result handshake.
interface float_expand_if;
    // Both handshakes use strict valid/ready semantics: a transfer happens
    // on a rising clk edge where valid & ready are both 1. Once valid is 1,
    // it and its payload stay stable until that edge. Ready may change freely.
    logic        in_valid;
    logic        in_ready;
    logic [10:0] DQ0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] DQ;
    logic        fmt_err;

    modport master (
        output in_valid,
        output DQ0,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  DQ,
        input  fmt_err
    );

    modport slave (
        input  in_valid,
        input  DQ0,
        input  out_ready,
        output in_ready,
        output out_valid,
        output DQ,
        output fmt_err
    );
endinterface

// File: rtl/float_expand.sv
// Converts a FLOATA-style floating sample {sign, E[3:0], M[5:0]} back to a
// 16-bit sign-magnitude linear value, one left shift per clock.
module float_expand #(
    parameter bit FAST_ZERO = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    float_expand_if.slave  bus,
    output logic [1:0]     dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [20:0] acc;
    logic [3:0]  cnt;
    logic        sign_r;

    logic        in_sign;
    logic [3:0]  in_e;
    logic [5:0]  in_m;
    logic        in_noncanon;

    // A canonical sample has a normalised mantissa, or is the zero code E=0, M=32.
    always_comb begin
        in_sign     = bus.DQ0[10];
        in_e        = bus.DQ0[9:6];
        in_m        = bus.DQ0[5:0];
        in_noncanon = (in_e != 4'd0) ? ~in_m[5] : (in_m != 6'b100000);
    end

    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            acc           <= 21'd0;
            cnt           <= 4'd0;
            sign_r        <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.DQ        <= 16'h0000;
            bus.fmt_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc          <= {15'd0, in_m};
                        cnt          <= in_e;
                        sign_r       <= in_sign;
                        bus.fmt_err  <= in_noncanon;
                        bus.in_ready <= 1'b0;
                        // With E=0 the 6-bit mantissa is shifted out entirely,
                        // so the magnitude is always zero.
                        if (FAST_ZERO && (in_e == 4'd0)) begin
                            bus.DQ        <= {in_sign, 15'd0};
                            bus.out_valid <= 1'b1;
                            state         <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (cnt != 4'd0) begin
                        acc <= {acc[19:0], 1'b0};
                        cnt <= cnt - 4'd1;
                    end else begin
                        bus.DQ        <= {sign_r, acc[20:6]};
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_expand.sv
// Self-checking bench for float_expand: directed vector table, multi-cycle
// corner sequences and a FLOATA round trip, checked through an expected queue.
module tb_float_expand;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;
    logic [1:0] dbg_state_z;

    float_expand_if bi ();
    float_expand_if bz ();

    float_expand #(.FAST_ZERO(1'b1)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bi),
        .dbg_state (dbg_state)
    );

    float_expand #(.FAST_ZERO(1'b0)) u_dut_slow (
        .clk       (clk),
        .reset     (reset),
        .bus       (bz),
        .dbg_state (dbg_state_z)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [16:0] exp_q[$];

    typedef struct {
        logic [10:0] dq0;
        logic [15:0] dq;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vec[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // scoreboard: every completed output handshake is compared with the queue head
    always @(negedge clk) begin
        if (!reset && bi.out_valid && bi.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got DQ=%h fmt_err=%b, expected none", bi.DQ, bi.fmt_err);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("result_dq_err", {15'd0, bi.DQ, bi.fmt_err}, {15'd0, e});
            end
        end
    end

    // driver: present one sample, return just after the accepting edge
    task automatic send(input logic [10:0] d, input bit push, input logic [16:0] e);
        int t;
        t = 0;
        while (!bi.in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 50) check("in_ready_timeout", 32'(bi.in_ready), 32'd1);
        bi.in_valid = 1'b1;
        bi.DQ0      = d;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        bi.in_valid = 1'b0;
        bi.DQ0      = 11'($urandom_range(0, 2047));
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bi.out_valid && lat < 40);
        if (!bi.out_valid) check("out_valid_timeout", 32'(bi.out_valid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] held;
        bit          seen;

        vec[0]  = '{11'h020, 16'h0000, 1'b0, 1};
        vec[1]  = '{11'h7FF, 16'hFE00, 1'b0, 17};
        vec[2]  = '{11'h5ED, 16'h805A, 1'b0, 9};
        vec[3]  = '{11'h060, 16'h0001, 1'b0, 3};
        vec[4]  = '{11'h0C0, 16'h0000, 1'b1, 5};
        vec[5]  = '{11'h010, 16'h0000, 1'b1, 1};
        vec[6]  = '{11'h420, 16'h8000, 1'b0, 1};
        vec[7]  = '{11'h3FF, 16'h7E00, 1'b0, 17};
        vec[8]  = '{11'h1C0, 16'h0000, 1'b1, 9};
        vec[9]  = '{11'h2A0, 16'h0200, 1'b0, 12};
        vec[10] = '{11'h22F, 16'h00BC, 1'b0, 10};

        reset        = 1'b1;
        bi.in_valid  = 1'b0;
        bi.DQ0       = 11'h000;
        bi.out_ready = 1'b1;
        bz.in_valid  = 1'b0;
        bz.DQ0       = 11'h000;
        bz.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(bi.in_ready), 32'd1);
        check("reset_out_valid", 32'(bi.out_valid), 32'd0);
        check("reset_dq", 32'(bi.DQ), 32'h0000);
        check("reset_fmt_err", 32'(bi.fmt_err), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // directed vector table; the first send accepts on the first edge after release
        for (int i = 0; i < 11; i++) begin
            send(vec[i].dq0, 1'b1, {vec[i].dq, vec[i].err});
            check($sformatf("busy_in_ready_%h", vec[i].dq0), 32'(bi.in_ready), 32'd0);
            wait_valid(lat);
            check($sformatf("latency_%h", vec[i].dq0), 32'(lat), 32'(vec[i].lat));
            @(posedge clk);
            #1;
        end

        // zero code without the fast path takes the SHIFT state once
        bz.in_valid = 1'b1;
        bz.DQ0      = 11'h020;
        @(posedge clk);
        #1;
        bz.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bz.out_valid && lat < 40);
        check("slow_zero_latency", 32'(lat), 32'd2);
        check("slow_zero_dq", 32'(bz.DQ), 32'h0000);
        check("slow_zero_fmt_err", 32'(bz.fmt_err), 32'd0);
        @(posedge clk);
        #1;

        // backpressure: result held for 5 cycles, new samples ignored meanwhile
        bi.out_ready = 1'b0;
        send(11'h5ED, 1'b1, {16'h805A, 1'b0});
        wait_valid(lat);
        held = bi.DQ;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            bi.in_valid = 1'b1;
            bi.DQ0      = 11'h7FF;
            @(negedge clk);
            check("bp_out_valid", 32'(bi.out_valid), 32'd1);
            check("bp_dq_stable", 32'(bi.DQ), 32'(held));
            check("bp_in_ready", 32'(bi.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bi.in_valid  = 1'b0;
        bi.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 32'(bi.in_ready), 32'd1);
        check("bp_release_out_valid", 32'(bi.out_valid), 32'd0);
        check("bp_release_state", 32'(dbg_state), 32'd0);

        // reset mid-SHIFT discards the pending conversion
        send(11'h3FF, 1'b0, 17'd0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_in_ready", 32'(bi.in_ready), 32'd1);
        check("abort_out_valid", 32'(bi.out_valid), 32'd0);
        check("abort_dq", 32'(bi.DQ), 32'h0000);
        check("abort_fmt_err", 32'(bi.fmt_err), 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bi.out_valid) seen = 1'b1;
        end
        check("abort_no_out_valid", 32'(seen), 32'd0);

        // round trip: FLOATA-encode random magnitudes, expect low bits dropped
        for (int n = 0; n < 44; n++) begin
            logic [14:0] mag;
            logic        s;
            int          e;
            logic [21:0] t;
            logic [5:0]  m;
            int          keep;
            case (n)
                0:       mag = 15'h0000;
                1:       mag = 15'h0001;
                2:       mag = 15'h7FFF;
                3:       mag = 15'h0040;
                default: mag = 15'($urandom_range(0, 32767) >> $urandom_range(0, 15));
            endcase
            s = 1'($urandom_range(0, 1));
            e = 0;
            for (int b = 0; b < 15; b++) if (mag[b]) e = b + 1;
            t = {7'd0, mag} << 6;
            t = t >> e;
            m = (mag == 15'd0) ? 6'd32 : t[5:0];
            keep = (e > 6) ? (int'(mag) & ~((1 << (e - 6)) - 1)) : int'(mag);
            send({s, 4'(e), m}, 1'b1, {s, 15'(keep), 1'b0});
            wait_valid(lat);
            check($sformatf("rt_latency_%h", mag), 32'(lat), (e == 0) ? 32'd1 : 32'(e + 2));
            @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
